// File: rtl/dc_pkg.sv
// Shared definitions for the sequential slice-by-slice magnitude comparator:
// result codes, FSM state encoding and cascade-input normalisation.
package dc_pkg;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_LT = 3'b010;
    localparam logic [2:0] CMP_EQ = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dcState_e;

    // Malformed cascade words (none or several bits set) read as "equal" so a
    // completed compare always reports exactly one relation.
    function automatic logic [2:0] normaliseCascade(input logic [2:0] cascade);
        logic [2:0] result;
        case (cascade)
            CMP_GT:  result = CMP_GT;
            CMP_LT:  result = CMP_LT;
            CMP_EQ:  result = CMP_EQ;
            default: result = CMP_EQ;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/data_compare_slice.sv
// Combinational unsigned compare of one SLICE-bit operand slice.
module data_compare_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] sliceA,
    input  logic [SLICE-1:0] sliceB,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    assign gt = (sliceA > sliceB);
    assign lt = (sliceA < sliceB);
    assign eq = (sliceA == sliceB);

endmodule

// File: rtl/data_compare_seq.sv
// Sequential WIDTH-bit magnitude comparator: one slice per clock, MSB slice
// first, early exit on the first differing slice, cascadable 3-bit result.
module data_compare_seq
    import dc_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int SLICE  = 4,
    localparam int NSLICE = WIDTH / SLICE
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iStart,
    input  logic             iSigned,
    input  logic [WIDTH-1:0] iData_a,
    input  logic [WIDTH-1:0] iData_b,
    input  logic [2:0]       iData,
    output logic             oBusy,
    output logic             oDone,
    output logic [2:0]       oData
);

    localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if ((WIDTH % SLICE) != 0 || NSLICE < 1) begin : gBadParams
            $error("data_compare_seq: WIDTH must be a non-zero multiple of SLICE");
        end
    endgenerate

    dcState_e        state;
    dcState_e        stateNext;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic             signedReg;
    logic [2:0]       cascReg;
    logic [IDXW-1:0]  index;

    logic [WIDTH-1:0] aEff;
    logic [WIDTH-1:0] bEff;
    logic [SLICE-1:0] sliceA;
    logic [SLICE-1:0] sliceB;
    logic             sliceGt;
    logic             sliceLt;
    logic             sliceEq;

    logic             load;
    logic             step;
    logic             finish;
    logic [2:0]       resultNext;

    // Flipping both sign bits maps two's-complement order onto unsigned
    // order, so the single unsigned slice comparator serves both modes.
    always_comb begin
        aEff = aReg;
        bEff = bReg;
        aEff[WIDTH-1] = aReg[WIDTH-1] ^ signedReg;
        bEff[WIDTH-1] = bReg[WIDTH-1] ^ signedReg;
    end

    assign sliceA = aEff[int'(index) * SLICE +: SLICE];
    assign sliceB = bEff[int'(index) * SLICE +: SLICE];

    data_compare_slice #(
        .SLICE (SLICE)
    ) uSlice (
        .sliceA (sliceA),
        .sliceB (sliceB),
        .gt     (sliceGt),
        .lt     (sliceLt),
        .eq     (sliceEq)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // DONE accepts a new start directly so back-to-back compares need no
    // idle cycle in between.
    always_comb begin
        stateNext = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (iStart) begin
                    load      = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (!sliceEq || index == '0) begin
                    finish    = 1'b1;
                    stateNext = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                if (iStart) begin
                    load      = 1'b1;
                    stateNext = RUN;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign resultNext = sliceGt ? CMP_GT : (sliceLt ? CMP_LT : cascReg);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            aReg      <= '0;
            bReg      <= '0;
            signedReg <= 1'b0;
            cascReg   <= CMP_EQ;
            index     <= '0;
            oData     <= 3'b000;
        end else begin
            if (load) begin
                aReg      <= iData_a;
                bReg      <= iData_b;
                signedReg <= iSigned;
                cascReg   <= normaliseCascade(iData);
                index     <= IDXW'(NSLICE - 1);
            end else if (step) begin
                index <= index - IDXW'(1);
            end
            if (finish) begin
                oData <= resultNext;
            end
        end
    end

    assign oBusy = (state == RUN);
    assign oDone = (state == DONE);

endmodule

// File: tb/tb_data_compare_seq.sv
// Self-checking bench for data_compare_seq: directed vector table, multi-cycle
// corner sequences and randomized compares against a behavioural model.
module tb_data_compare_seq;

    localparam int W  = 16;
    localparam int S  = 4;
    localparam int NS = W / S;

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] LT = 3'b010;
    localparam logic [2:0] EQ = 3'b001;

    logic         iClk;
    logic         iRst_n;
    logic         iStart;
    logic         iSigned;
    logic [W-1:0] iData_a;
    logic [W-1:0] iData_b;
    logic [2:0]   iData;
    logic         oBusy;
    logic         oDone;
    logic [2:0]   oData;

    int         compared;
    int         mismatched;
    logic [2:0] lastResult;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sgn;
        logic [2:0]   casc;
        logic [2:0]   expRes;
        int           expLat;
    } vec_t;

    vec_t vecs[11];

    data_compare_seq #(
        .WIDTH (W),
        .SLICE (S)
    ) dut (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .iStart  (iStart),
        .iSigned (iSigned),
        .iData_a (iData_a),
        .iData_b (iData_b),
        .iData   (iData),
        .oBusy   (oBusy),
        .oDone   (oDone),
        .oData   (oData)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Reference: relation from plain integer arithmetic; latency from the
    // position of the highest differing bit.
    function automatic logic [2:0] refResult(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sgn, input logic [2:0] casc);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        sa = a;
        sb = b;
        if (sgn ? (sa > sb) : (a > b)) return GT;
        if (sgn ? (sa < sb) : (a < b)) return LT;
        if (casc == GT || casc == LT) return casc;
        return EQ;
    endfunction

    function automatic int refLatency(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] diff;
        diff = a ^ b;
        for (int i = W - 1; i >= 0; i--) begin
            if (diff[i]) return NS - (i / S);
        end
        return NS;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge
    // one cycle after the done pulse. pulseCycle>0 re-pulses iStart mid-run.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                 input logic [2:0] casc, input logic [2:0] expRes, input int expLat,
                                 input int pulseCycle, input string tag);
        int   busyCount;
        int   cycles;
        logic holdBad;
        iData_a = a;
        iData_b = b;
        iSigned = sgn;
        iData   = casc;
        iStart  = 1'b1;
        busyCount = 0;
        cycles    = 0;
        holdBad   = 1'b0;
        @(negedge iClk);
        iStart = 1'b0;
        while (!oDone && cycles < 20) begin
            if (oBusy) busyCount++;
            if (oData !== lastResult) holdBad = 1'b1;
            cycles++;
            iStart  = (cycles == pulseCycle);
            iData_a = W'($urandom);
            iData_b = W'($urandom);
            iSigned = 1'($urandom);
            iData   = 3'($urandom);
            @(negedge iClk);
        end
        iStart = 1'b0;
        checkOutput({tag, " latency"}, busyCount, expLat);
        checkOutput({tag, " done"}, oDone, 1);
        checkOutput({tag, " result"}, oData, expRes);
        checkOutput({tag, " hold"}, holdBad, 0);
        lastResult = expRes;
        @(negedge iClk);
        checkOutput({tag, " pulse end"}, {oBusy, oDone}, 0);
        checkOutput({tag, " result kept"}, oData, expRes);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        logic [2:0]   rc;
        int           cnt;
        int           cycles;
        logic         holdBad;
        logic         doneSeen;

        compared   = 0;
        mismatched = 0;
        lastResult = 3'b000;

        vecs[0]  = '{16'h8000, 16'h7FFF, 1'b0, 3'b000, GT, 1};
        vecs[1]  = '{16'h8000, 16'h7FFF, 1'b1, 3'b000, LT, 1};
        vecs[2]  = '{16'h1234, 16'h1235, 1'b0, 3'b000, LT, 4};
        vecs[3]  = '{16'hABCD, 16'hABCD, 1'b0, 3'b100, GT, 4};
        vecs[4]  = '{16'hABCD, 16'hABCD, 1'b0, 3'b010, LT, 4};
        vecs[5]  = '{16'hABCD, 16'hABCD, 1'b0, 3'b001, EQ, 4};
        vecs[6]  = '{16'hABCD, 16'hABCD, 1'b0, 3'b011, EQ, 4};
        vecs[7]  = '{16'hABCD, 16'hABCD, 1'b1, 3'b000, EQ, 4};
        vecs[8]  = '{16'h0F00, 16'h0E00, 1'b1, 3'b010, GT, 2};
        vecs[9]  = '{16'hFFFF, 16'h0001, 1'b1, 3'b100, LT, 1};
        vecs[10] = '{16'h1200, 16'h1300, 1'b0, 3'b100, LT, 2};

        iRst_n  = 1'b0;
        iStart  = 1'b0;
        iSigned = 1'b0;
        iData_a = '0;
        iData_b = '0;
        iData   = 3'b000;
        repeat (2) @(negedge iClk);
        checkOutput("reset busy", oBusy, 0);
        checkOutput("reset done", oDone, 0);
        checkOutput("reset data", oData, 3'b000);
        iRst_n = 1'b1;
        @(negedge iClk);
        checkOutput("post-reset idle", {oBusy, oDone}, 0);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].casc,
                          vecs[i].expRes, vecs[i].expLat, 0, $sformatf("vec%0d", i));
        end

        // iStart pulsed during the second RUN cycle must not restart anything.
        applyStimulus(16'h1234, 16'h1235, 1'b0, 3'b000, LT, 4, 2, "ignore start");

        // Reset during the second RUN cycle abandons the compare.
        iData_a = 16'h0001;
        iData_b = 16'h0002;
        iSigned = 1'b0;
        iData   = 3'b000;
        iStart  = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        @(negedge iClk);
        checkOutput("midreset busy before", oBusy, 1);
        #2 iRst_n = 1'b0;
        #1;
        checkOutput("midreset busy", oBusy, 0);
        checkOutput("midreset done", oDone, 0);
        checkOutput("midreset data", oData, 3'b000);
        doneSeen = 1'b0;
        repeat (3) begin
            @(negedge iClk);
            if (oDone || oBusy) doneSeen = 1'b1;
        end
        iRst_n = 1'b1;
        lastResult = 3'b000;
        @(negedge iClk);
        if (oDone || oBusy) doneSeen = 1'b1;
        checkOutput("midreset no pulse", doneSeen, 0);
        applyStimulus(16'h0003, 16'h0002, 1'b0, 3'b000, GT, 4, 0, "after reset");

        // Back-to-back: iStart held high through DONE.
        iData_a = 16'h5000;
        iData_b = 16'h4000;
        iSigned = 1'b0;
        iData   = 3'b000;
        iStart  = 1'b1;
        @(negedge iClk);
        checkOutput("b2b busy first", oBusy, 1);
        iData_a = 16'h0001;
        iData_b = 16'h0002;
        @(negedge iClk);
        checkOutput("b2b done first", oDone, 1);
        checkOutput("b2b result first", oData, GT);
        @(negedge iClk);
        checkOutput("b2b no idle gap", oBusy, 1);
        checkOutput("b2b first held", oData, GT);
        iStart  = 1'b0;
        cnt     = 1;
        cycles  = 0;
        holdBad = 1'b0;
        @(negedge iClk);
        while (!oDone && cycles < 20) begin
            if (oBusy) cnt++;
            if (oData !== GT) holdBad = 1'b1;
            cycles++;
            @(negedge iClk);
        end
        checkOutput("b2b latency second", cnt, 4);
        checkOutput("b2b done second", oDone, 1);
        checkOutput("b2b result second", oData, LT);
        checkOutput("b2b hold second", holdBad, 0);
        lastResult = LT;
        @(negedge iClk);
        checkOutput("b2b idle", {oBusy, oDone}, 0);

        for (int n = 0; n < 150; n++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = W'($urandom);
                1:       rb = ra;
                2:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
                default: rb = ra ^ W'($urandom_range(0, 15));
            endcase
            rs = 1'($urandom);
            rc = 3'($urandom);
            applyStimulus(ra, rb, rs, rc, refResult(ra, rb, rs, rc), refLatency(ra, rb),
                          0, $sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/data_compare_seq.md
Name: data_compare_seq

Overview:
- Parametrised, sequential successor to the 4-bit cascadable magnitude comparator.
- Compares two WIDTH-bit operands one SLICE-bit slice per clock, MSB slice first, and stops early as soon as a slice differs.
- Supports unsigned or two's-complement comparison per operation and keeps the three-bit cascade input (a>b, a<b, a=b), so wide compares chain with existing comparator stages.
- Used wherever wide compares must share one narrow slice comparator instead of flattening into a deep combinational tree.

Parameters:
- WIDTH, 16: operand width in bits; must be a multiple of SLICE.
- SLICE, 4: bits compared per cycle.
- NSLICE, WIDTH/SLICE: number of slices; derived, not overridden.

Ports:
- iClk  input  1  clock; all state updates on the rising edge.
- iRst_n  input  1  reset; asynchronous, active-low.
- iStart  input  1  request a compare; sampled only while oBusy=0.
- iSigned  input  1  1 = two's-complement compare, 0 = unsigned; latched at start.
- iData_a  input  WIDTH  operand a; latched at start.
- iData_b  input  WIDTH  operand b; latched at start.
- iData  input  3  cascade input {a>b, a<b, a=b}; latched at start.
- oBusy  output  1  compare in progress.
- oDone  output  1  one-cycle pulse; result valid.
- oData  output  3  result {A>B, A<B, A=B}; holds until the next result.

Behaviour:
- Reset:
  - While iRst_n=0, asynchronously force state=IDLE, oBusy=0, oDone=0, oData=3'b000 and clear the slice index.
  - Reset asserted mid-operation abandons the compare; no result is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE or DONE with iStart=1 at an edge: latch operands, iSigned and cascade; set index=NSLICE-1; go to RUN; oBusy=1 after that edge.
  - IDLE with iStart=0: stay in IDLE.
  - DONE with iStart=0: go to IDLE. Back-to-back starts are allowed from DONE.
  - RUN: each edge compares the slice at the current index.
    - Slice differs: register GT (3'b100) or LT (3'b010), then go to DONE.
    - Slice equal and index=0: register the cascade result, then go to DONE.
    - Slice equal and index>0: decrement index, stay in RUN.
  - oDone=1 only in DONE. oBusy=1 only in RUN.
- Signed mode: invert bit WIDTH-1 of both latched operands before the MSB slice compare; other slices compare unsigned.
- Cascade result when all slices are equal:
  - 3'b100 gives 100; 3'b010 gives 010; 3'b001 gives 001.
  - Any other value (including 000) gives 3'b001.
- Latency from the start edge to the result edge: j cycles, where j is the 1-based position from the MSB of the first differing slice; NSLICE cycles if all slices are equal. oDone rises after the result edge.
- iStart is ignored while in RUN; input changes during RUN have no effect.
- oData changes only on a result edge or on reset.
- Exactly one of the three oData bits is high after any completed compare.

Decomposition:
- Shared package dc_pkg holds:
  - result constants CMP_GT=3'b100, CMP_LT=3'b010, CMP_EQ=3'b001;
  - the state encoding IDLE/RUN/DONE;
  - a function that normalises the cascade input.
- One sub-module, data_compare_slice: combinational SLICE-bit compare producing gt/lt/eq, instantiated once and fed by a slice mux on the index.

Test Plan (WIDTH=16, SLICE=4):
- Unsigned MSB difference: a=16'h8000, b=16'h7FFF, iSigned=0, iData=000 -> oData=100, oDone 1 cycle after start edge, oBusy high 1 cycle.
- Signed MSB difference: same operands, iSigned=1 -> oData=010 after 1 cycle.
- Last-slice difference: a=16'h1234, b=16'h1235, unsigned -> oData=010 after 4 cycles; oBusy high 4 cycles; iStart pulsed in cycle 2 is ignored.
- Equal operands with cascade: a=b=16'hABCD, iData=100 -> 100; 010 -> 010; 001 -> 001; 011 -> 001; 000 -> 001; each after 4 cycles.
- Reset mid-operation: start a=16'h0001, b=16'h0002; drop iRst_n during the 2nd RUN cycle -> oBusy, oDone, oData all 0 immediately, no oDone pulse. After release, a=16'h0003, b=16'h0002 -> oData=100 after 4 cycles.
- Back-to-back: iStart held high through DONE -> second compare is latched in the DONE cycle and oBusy re-asserts with no IDLE gap; the first result stays on oData until the second result edge.
